// File: rtl/psk_cfg_pkg.sv
// psk_cfg_pkg: shared definitions for the PSK configuration register bank.
// Holds the register index map, the per-field width table, the masks derived
// from it, the reset-value table and the commit FSM state type.
package psk_cfg_pkg;

    localparam int NUM_FIELDS = 9;

    localparam int ADDR_DELAY_CNT       = 0;
    localparam int ADDR_MODE_CTRL       = 1;
    localparam int ADDR_FEEDBACK_SHIFT  = 2;
    localparam int ADDR_GARDNER_SHIFT   = 3;
    localparam int ADDR_RX_SD_THRESHOLD = 4;
    localparam int ADDR_RX_SD_WINDOW    = 5;
    localparam int ADDR_RX_PD_WINDOW    = 6;
    localparam int ADDR_RX_BD_WINDOW    = 7;
    localparam int ADDR_TX_PHASE_CONFIG = 8;

    // Meaningful bits per field; anything above is forced to zero on write.
    localparam int unsigned FIELD_W [NUM_FIELDS] = '{
        32'd8, 32'd4, 32'd4, 32'd4, 32'd16, 32'd8, 32'd8, 32'd8, 32'd16
    };

    // Turns a field width into a right-aligned mask.
    function automatic logic [31:0] width_to_mask(input int unsigned w);
        logic [31:0] mask;
        if (w >= 32'd32) begin
            mask = 32'hFFFF_FFFF;
        end else begin
            mask = (32'd1 << w) - 32'd1;
        end
        return mask;
    endfunction

    localparam logic [31:0] FIELD_MASK [NUM_FIELDS] = '{
        width_to_mask(FIELD_W[0]), width_to_mask(FIELD_W[1]), width_to_mask(FIELD_W[2]),
        width_to_mask(FIELD_W[3]), width_to_mask(FIELD_W[4]), width_to_mask(FIELD_W[5]),
        width_to_mask(FIELD_W[6]), width_to_mask(FIELD_W[7]), width_to_mask(FIELD_W[8])
    };

    localparam logic [31:0] RESET_VAL [NUM_FIELDS] = '{
        32'd8, 32'd4, 32'd0, 32'd3, 32'd128, 32'd16, 32'd16, 32'd16, 32'd8192
    };

    // Mask lookup that tolerates banks larger than the field table (extra
    // registers are stored full width).
    function automatic logic [31:0] field_mask_of(input int idx);
        logic [31:0] mask;
        if (idx < NUM_FIELDS) begin
            mask = FIELD_MASK[idx[3:0]];
        end else begin
            mask = 32'hFFFF_FFFF;
        end
        return mask;
    endfunction

    // Reset lookup; registers beyond the field table reset to zero.
    function automatic logic [31:0] reset_val_of(input int idx);
        logic [31:0] val;
        if (idx < NUM_FIELDS) begin
            val = RESET_VAL[idx[3:0]];
        end else begin
            val = 32'd0;
        end
        return val;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/psk_cfg_commit_fsm.sv
// psk_cfg_commit_fsm: sequences a configuration commit.
// IDLE accepts writes; a commit request waits in PENDING for a frame boundary
// (or the optional timeout), then a single APPLY cycle tells the bank to copy
// shadow into active. Writes are refused outside IDLE so the shadow set that
// gets applied is frozen from the moment the commit is requested.
module psk_cfg_commit_fsm
    import psk_cfg_pkg::*;
#(
    parameter int unsigned BOUNDARY_TIMEOUT = 65535
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic commit_req_i,
    input  logic frame_boundary_i,
    output logic wr_ready_o,
    output logic commit_pending_o,
    output logic cfg_update_o,
    output logic apply_o
);

    // Counter only needs to reach BOUNDARY_TIMEOUT-1; it then saturates.
    localparam int unsigned CNT_W = (BOUNDARY_TIMEOUT < 32'd2) ? 1 : $clog2(BOUNDARY_TIMEOUT);
    localparam bit TIMEOUT_EN = (BOUNDARY_TIMEOUT != 32'd0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        TIMEOUT_EN ? CNT_W'(BOUNDARY_TIMEOUT - 32'd1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    cfg_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wr_ready_q;
    logic             commit_pending_q;
    logic             cfg_update_q;
    logic             timeout_hit_s;

    assign timeout_hit_s = TIMEOUT_EN && (cnt_q == CNT_LAST);

    // Commit state machine with timeout counter and registered handshake/status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= ST_IDLE;
            cnt_q            <= {CNT_W{1'b0}};
            wr_ready_q       <= 1'b0;
            commit_pending_q <= 1'b0;
            cfg_update_q     <= 1'b0;
        end else begin
            cfg_update_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (commit_req_i) begin
                        if (frame_boundary_i) begin
                            state_q <= ST_APPLY;
                        end else begin
                            state_q <= ST_PENDING;
                            cnt_q   <= {CNT_W{1'b0}};
                        end
                        wr_ready_q       <= 1'b0;
                        commit_pending_q <= 1'b1;
                    end else begin
                        wr_ready_q       <= 1'b1;
                        commit_pending_q <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    // Further commit requests merge into this one.
                    if (frame_boundary_i || timeout_hit_s) begin
                        state_q <= ST_APPLY;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        cnt_q <= cnt_q;
                    end
                    wr_ready_q       <= 1'b0;
                    commit_pending_q <= 1'b1;
                end
                ST_APPLY: begin
                    state_q          <= ST_IDLE;
                    cfg_update_q     <= 1'b1;
                    wr_ready_q       <= 1'b1;
                    commit_pending_q <= 1'b0;
                end
                default: begin
                    state_q          <= ST_IDLE;
                    wr_ready_q       <= 1'b0;
                    commit_pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready_o       = wr_ready_q;
    assign commit_pending_o = commit_pending_q;
    assign cfg_update_o     = cfg_update_q;
    assign apply_o          = (state_q == ST_APPLY);

endmodule

// File: rtl/psk_cfg_regbank.sv
// psk_cfg_regbank: double-buffered configuration registers for the PSK modem.
// Software writes land in a shadow bank; a commit copies the whole shadow bank
// into the active bank atomically at a frame boundary so the datapath never
// sees a half-updated configuration.
// Optional feature: define PSK_CFG_READBACK_EN to add a registered readback
// port (rd_addr / rd_sel / rd_data) for the shadow or active bank.
module psk_cfg_regbank
    import psk_cfg_pkg::*;
#(
    parameter int          NUM_REGS         = 9,
    parameter int          DATA_W           = 16,
    parameter int          ADDR_W           = 4,
    parameter int unsigned BOUNDARY_TIMEOUT = 65535
) (
    input  logic                       clk_16M384,
    input  logic                       rst_n_16M384,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       commit_req,
    input  logic                       frame_boundary,
    output logic [NUM_REGS*DATA_W-1:0] cfg_active,
    output logic                       cfg_update,
    output logic                       commit_pending,
    output logic                       wr_err
`ifdef PSK_CFG_READBACK_EN
    ,
    input  logic [ADDR_W-1:0]          rd_addr,
    input  logic                       rd_sel,
    output logic [DATA_W-1:0]          rd_data
`endif
);

    // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] shadow_q [NUM_REGS];
    logic [DATA_W-1:0] active_q [NUM_REGS];
    logic              wr_err_q;
    logic              wr_ready_s;
    logic              wr_fire_s;
    logic              wr_oor_s;
    logic              apply_s;

    psk_cfg_commit_fsm #(
        .BOUNDARY_TIMEOUT(BOUNDARY_TIMEOUT)
    ) u_commit_fsm (
        .clk_i           (clk_16M384),
        .rst_ni          (rst_n_16M384),
        .commit_req_i    (commit_req),
        .frame_boundary_i(frame_boundary),
        .wr_ready_o      (wr_ready_s),
        .commit_pending_o(commit_pending),
        .cfg_update_o    (cfg_update),
        .apply_o         (apply_s)
    );

    assign wr_fire_s = wr_valid && wr_ready_s;
    assign wr_oor_s  = ({1'b0, wr_addr} >= NUM_REGS_A);
    assign wr_ready  = wr_ready_s;

    // Shadow bank: masked write of the addressed register on an accepted handshake.
    always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
        if (!rst_n_16M384) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= DATA_W'(reset_val_of(i));
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_fire_s && (wr_addr == ADDR_W'(i))) begin
                    shadow_q[i] <= wr_data & DATA_W'(field_mask_of(i));
                end else begin
                    shadow_q[i] <= shadow_q[i];
                end
            end
        end
    end

    // Active bank: whole-bank copy from shadow on the single APPLY cycle.
    always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
        if (!rst_n_16M384) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active_q[i] <= DATA_W'(reset_val_of(i));
            end
        end else if (apply_s) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active_q[i] <= active_q[i];
            end
        end
    end

    // Error pulse for an accepted write aimed past the last register.
    always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
        if (!rst_n_16M384) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_fire_s && wr_oor_s;
        end
    end

    assign wr_err = wr_err_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_active[g*DATA_W +: DATA_W] = active_q[g];
    end

`ifdef PSK_CFG_READBACK_EN
    logic [DATA_W-1:0] rd_mux_s;
    logic [DATA_W-1:0] rd_data_q;

    // Readback select: OR of one-hot matches, so unmatched addresses read 0.
    always_comb begin
        rd_mux_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_mux_s = rd_mux_s | ({DATA_W{rd_addr == ADDR_W'(i)}} &
                                   (rd_sel ? active_q[i] : shadow_q[i]));
        end
    end

    // Readback register giving one cycle of latency.
    always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
        if (!rst_n_16M384) begin
            rd_data_q <= {DATA_W{1'b0}};
        end else begin
            rd_data_q <= rd_mux_s;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_psk_cfg_regbank.sv
// tb_psk_cfg_regbank: self-checking bench for psk_cfg_regbank.
// Three instances (default timeout, timeout 16, timeout disabled) share one
// stimulus stream; a transaction-level model per instance predicts every output
// after every clock edge. Directed scenarios are followed by a random phase.
module tb_psk_cfg_regbank;

    localparam int NR = 9;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          commit_req = 1'b0;
    logic          frame_boundary = 1'b0;

    logic [NR*DW-1:0] act_w [NI];
    logic             rdy_w [NI];
    logic             upd_w [NI];
    logic             pend_w [NI];
    logic             err_w [NI];

    always #5 clk = ~clk;

    psk_cfg_regbank #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW)) u_dut_dflt (
        .clk_16M384(clk), .rst_n_16M384(rst_n), .wr_valid(wr_valid), .wr_ready(rdy_w[0]),
        .wr_addr(wr_addr), .wr_data(wr_data), .commit_req(commit_req),
        .frame_boundary(frame_boundary), .cfg_active(act_w[0]), .cfg_update(upd_w[0]),
        .commit_pending(pend_w[0]), .wr_err(err_w[0])
    );

    psk_cfg_regbank #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .BOUNDARY_TIMEOUT(16)) u_dut_t16 (
        .clk_16M384(clk), .rst_n_16M384(rst_n), .wr_valid(wr_valid), .wr_ready(rdy_w[1]),
        .wr_addr(wr_addr), .wr_data(wr_data), .commit_req(commit_req),
        .frame_boundary(frame_boundary), .cfg_active(act_w[1]), .cfg_update(upd_w[1]),
        .commit_pending(pend_w[1]), .wr_err(err_w[1])
    );

    psk_cfg_regbank #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .BOUNDARY_TIMEOUT(0)) u_dut_t0 (
        .clk_16M384(clk), .rst_n_16M384(rst_n), .wr_valid(wr_valid), .wr_ready(rdy_w[2]),
        .wr_addr(wr_addr), .wr_data(wr_data), .commit_req(commit_req),
        .frame_boundary(frame_boundary), .cfg_active(act_w[2]), .cfg_update(upd_w[2]),
        .commit_pending(pend_w[2]), .wr_err(err_w[2])
    );

    // Reference tables written straight from the register map.
    int unsigned rst_tab [NR] = '{8, 4, 0, 3, 128, 16, 16, 16, 8192};
    int unsigned fw_tab  [NR] = '{8, 4, 4, 4, 16, 8, 8, 8, 16};
    int unsigned to_tab  [NI] = '{65535, 16, 0};

    // Model: shadow/active contents plus commit bookkeeping per instance.
    int unsigned m_shadow [NI][NR];
    int unsigned m_active [NI][NR];
    bit          m_ready  [NI];
    bit          m_upd    [NI];
    bit          m_err    [NI];
    bit          m_wait   [NI];   // commit requested, waiting for boundary/timeout
    bit          m_load   [NI];   // next edge copies shadow to active
    int          m_waited [NI];   // cycles spent waiting so far

    int n_total = 0;
    int n_pass  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned fmask(input int idx);
        return (32'd1 << fw_tab[idx]) - 32'd1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < NR; i++) begin
                m_shadow[k][i] = rst_tab[i];
                m_active[k][i] = rst_tab[i];
            end
            m_ready[k] = 1'b0; m_upd[k] = 1'b0; m_err[k] = 1'b0;
            m_wait[k] = 1'b0; m_load[k] = 1'b0; m_waited[k] = 0;
        end
    endtask

    // Predicts the effect of one clock edge given the inputs presented before it.
    task automatic model_edge(input bit v, input int a, input int d, input bit c, input bit b);
        for (int k = 0; k < NI; k++) begin
            bit accept;
            accept   = v && m_ready[k];
            m_err[k] = accept && (a >= NR);
            if (accept && a < NR) m_shadow[k][a] = int'(d) & fmask(a);
            m_upd[k] = m_load[k];
            if (m_load[k]) begin
                for (int i = 0; i < NR; i++) m_active[k][i] = m_shadow[k][i];
                m_load[k] = 1'b0;
            end else if (m_wait[k]) begin
                m_waited[k]++;
                if (b || (to_tab[k] != 0 && m_waited[k] == int'(to_tab[k]))) begin
                    m_wait[k] = 1'b0;
                    m_load[k] = 1'b1;
                end
            end else if (c) begin
                if (b) begin
                    m_load[k] = 1'b1;
                end else begin
                    m_wait[k]   = 1'b1;
                    m_waited[k] = 0;
                end
            end
            m_ready[k] = !(m_wait[k] || m_load[k]);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < NR; i++) begin
                check_eq($sformatf("i%0d active[%0d]", k, i), {16'd0, act_w[k][i*DW +: DW]}, m_active[k][i]);
            end
            check_eq($sformatf("i%0d wr_ready", k), {31'd0, rdy_w[k]}, {31'd0, m_ready[k]});
            check_eq($sformatf("i%0d cfg_update", k), {31'd0, upd_w[k]}, {31'd0, m_upd[k]});
            check_eq($sformatf("i%0d wr_err", k), {31'd0, err_w[k]}, {31'd0, m_err[k]});
            check_eq($sformatf("i%0d commit_pending", k), {31'd0, pend_w[k]},
                     {31'd0, (m_wait[k] || m_load[k])});
        end
    endtask

    task automatic step(input bit v, input int a, input int d, input bit c, input bit b);
        wr_valid = v; wr_addr = AW'(a); wr_data = DW'(d); commit_req = c; frame_boundary = b;
        model_edge(v, a, d, c, b);
        @(posedge clk);
        #1;
        wr_valid = 1'b0; commit_req = 1'b0; frame_boundary = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        wr_valid = 1'b0; commit_req = 1'b0; frame_boundary = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();
    endtask

    initial begin
        int cyc;

        // Reset release: reset values, wr_ready rises on first edge.
        do_reset();
        check_eq("rst wr_ready low", {31'd0, rdy_w[0]}, 32'd0);
        idle(1);
        check_eq("rst wr_ready up", {31'd0, rdy_w[0]}, 32'd1);
        check_eq("rst tx_phase", {16'd0, act_w[0][8*DW +: DW]}, 32'd8192);
        check_eq("rst sd_thresh", {16'd0, act_w[0][4*DW +: DW]}, 32'd128);

        // Masked write, commit, boundary ten cycles later.
        step(1'b1, 3, 16'hFFFF, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        idle(9);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        check_eq("gardner not yet", {16'd0, act_w[0][3*DW +: DW]}, 32'd3);
        idle(1);
        check_eq("gardner applied", {16'd0, act_w[0][3*DW +: DW]}, 32'h000F);
        check_eq("update pulse", {31'd0, upd_w[0]}, 32'd1);
        idle(1);
        check_eq("update single", {31'd0, upd_w[0]}, 32'd0);

        // Out-of-range write: error pulse, commit leaves values unchanged.
        step(1'b1, 12, 16'h1234, 1'b0, 1'b0);
        check_eq("oor wr_err", {31'd0, err_w[0]}, 32'd1);
        idle(1);
        step(1'b0, 0, 0, 1'b1, 1'b1);
        idle(2);
        check_eq("oor delay_cnt kept", {16'd0, act_w[0][0 +: DW]}, 32'd8);

        // Timeout: 16-cycle instance applies alone; others keep waiting.
        step(1'b0, 0, 0, 1'b1, 1'b0);
        cyc = 0;
        while (!upd_w[1] && cyc < 40) begin
            idle(1);
            cyc++;
        end
        check_eq("t16 apply latency", cyc, 32'd17);
        idle(100);
        check_eq("t0 still pending", {31'd0, pend_w[2]}, 32'd1);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle(2);

        // Commit and boundary together with a write: direct apply.
        step(1'b1, 8, 4096, 1'b1, 1'b1);
        idle(1);
        check_eq("direct tx_phase", {16'd0, act_w[0][8*DW +: DW]}, 32'd4096);
        check_eq("direct update", {31'd0, upd_w[0]}, 32'd1);

        // Reset during the wait aborts the commit.
        step(1'b1, 1, 2, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        idle(3);
        rst_n = 1'b0;
        #2;
        check_eq("abort mode_ctrl", {16'd0, act_w[0][1*DW +: DW]}, 32'd4);
        check_eq("abort pending", {31'd0, pend_w[0]}, 32'd0);
        do_reset();
        idle(2);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 65535)), ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 4) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/psk_cfg_regbank.md
PSK_CFG_REGBANK -- requirements
Module: psk_cfg_regbank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 9: number of configuration registers.
REQ-002 SHALL have parameter DATA_W, default 16: storage width of each register.
REQ-003 SHALL have parameter ADDR_W, default 4: write-address width; NUM_REGS <= 2**ADDR_W.
REQ-004 SHALL have parameter BOUNDARY_TIMEOUT, default 65535: cycles in PENDING before a forced apply; 0 disables the timeout.
REQ-005 SHALL have port clk_16M384  input  1: the single clock.
REQ-006 SHALL have port rst_n_16M384  input  1: asynchronous, active-low reset.
REQ-007 SHALL have port wr_valid  input  1: write request.
REQ-008 SHALL have port wr_ready  output  1: write accept, registered.
REQ-009 SHALL have port wr_addr  input  ADDR_W: target register index.
REQ-010 SHALL have port wr_data  input  DATA_W: write value.
REQ-011 SHALL have port commit_req  input  1: request to copy shadow to active.
REQ-012 SHALL have port frame_boundary  input  1: safe-point strobe, e.g. the Tx/Rx tlast.
REQ-013 SHALL have port cfg_active  output  NUM_REGS*DATA_W: register i at [i*DATA_W +: DATA_W].
REQ-014 SHALL have port cfg_update  output  1: one-cycle pulse in the first cycle new values are visible.
REQ-015 SHALL have port commit_pending  output  1: high while state != IDLE.
REQ-016 SHALL have port wr_err  output  1: one-cycle pulse on an out-of-range write.

Function
REQ-017 Write handshake: a write SHALL complete on a clock edge where wr_valid && wr_ready. The edge SHALL store shadow[wr_addr] <= wr_data & FIELD_MASK[wr_addr].
REQ-018 Out-of-range address (wr_addr >= NUM_REGS): the handshake SHALL complete, nothing SHALL be stored, and wr_err SHALL be high in the following cycle.
REQ-019 FSM states SHALL be IDLE, PENDING and APPLY. wr_ready SHALL be 1 only in IDLE, so the shadow set is frozen once a commit is requested.
REQ-020 IDLE SHALL go to PENDING on commit_req. If frame_boundary is high in the same cycle, IDLE SHALL go directly to APPLY.
REQ-021 PENDING SHALL go to APPLY on frame_boundary, or when the timeout counter reaches BOUNDARY_TIMEOUT-1 (only if BOUNDARY_TIMEOUT != 0).
REQ-022 APPLY SHALL last one cycle. On its closing edge, all NUM_REGS active registers SHALL load from shadow atomically, cfg_update SHALL be set for one cycle, and the state SHALL return to IDLE.
REQ-023 Latency: from the edge sampling frame_boundary, new cfg_active values and cfg_update SHALL become visible 2 edges later.
REQ-024 commit_req received in PENDING or APPLY SHALL be ignored (merged into the outstanding commit).
REQ-025 A write accepted in the same IDLE cycle as commit_req SHALL be included in the commit.
REQ-026 The timeout counter SHALL clear on entry to PENDING and SHALL saturate, never wrap.
REQ-027 cfg_active SHALL change only on the APPLY edge; no partial update SHALL ever be visible.

Reset
REQ-028 On rst_n_16M384 low, shadow and active SHALL both be set to RESET_VAL[i] from the package: DELAY_CNT 8, MODE_CTRL 4, FEEDBACK_SHIFT 0, GARDNER_SHIFT 3, RX_SD_THRESHOLD 128, RX_SD_WINDOW 16, RX_PD_WINDOW 16, RX_BD_WINDOW 16, TX_PHASE_CONFIG 8192.
REQ-029 Reset SHALL put the state in IDLE and set wr_ready, cfg_update, wr_err, commit_pending and the counter to 0. wr_ready SHALL rise on the first edge after release.
REQ-030 Reset asserted mid-PENDING or mid-APPLY SHALL abort the commit; active SHALL hold RESET_VAL.

Configuration
REQ-031 Macro PSK_CFG_READBACK_EN defined: the block SHALL add ports rd_addr (input, ADDR_W), rd_sel (input, 1; 0=shadow, 1=active) and rd_data (output, DATA_W, reset 0). rd_data SHALL have 1-cycle registered latency and SHALL return 0 for out-of-range addresses.
REQ-032 Macro PSK_CFG_READBACK_EN undefined: the readback ports and logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 Package psk_cfg_pkg SHALL hold the register index constants (ADDR_DELAY_CNT=0 ... ADDR_TX_PHASE_CONFIG=8, in REQ-028 order), the FIELD_W table {8,4,4,4,16,8,8,8,16}, the derived FIELD_MASK, the RESET_VAL table and the state enum.
REQ-034 Sub-module psk_cfg_commit_fsm SHALL contain the FSM and timeout counter; the register arrays SHALL stay in the top module.

Verification
REQ-035 The bench SHALL cover: reset release -> cfg_active slices equal REQ-028 values, wr_ready=1 after the first edge.
REQ-036 The bench SHALL cover: write addr 3 data 0xFFFF, commit_req, frame_boundary 10 cycles later -> GARDNER_SHIFT=0x000F exactly 2 edges after the boundary, cfg_update pulses once.
REQ-037 The bench SHALL cover: write addr 12 -> wr_err pulse, no shadow change, a later commit leaves all active values unchanged.
REQ-038 The bench SHALL cover: BOUNDARY_TIMEOUT=16, commit_req, no boundary -> APPLY after 16 PENDING cycles. BOUNDARY_TIMEOUT=0 -> stays PENDING indefinitely.
REQ-039 The bench SHALL cover: commit_req and frame_boundary in the same cycle with a write to addr 8 = 4096 -> TX_PHASE_CONFIG=4096 applied, no PENDING cycle.
REQ-040 The bench SHALL cover: reset asserted during PENDING after a write to addr 1 = 2 -> MODE_CTRL stays 4, commit_pending=0.
